key_input: RTL and testbench

- Front-end for raw push-button / key inputs, e.g. elevator call and floor buttons.
- Synchronises each of W asynchronous key lines into the clk domain and debounces each line independently.
- Emits a single-cycle pulse on key_press[i] for each debounced press (0->1) of key i.
- Downstream request-latching logic consumes key_press directly; no handshake.

---
 rtl/key_input_pkg.sv | 14 +
 rtl/key_debounce_bit.sv | 81 ++++++++
 rtl/key_input.sv | 36 +++
 tb/tb_key_input.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_input_pkg.sv
// Shared constants and helpers for the key_input debouncer slice.
// Optional release pulses are enabled by defining KEY_INPUT_RELEASE_EN.
package key_input_pkg;

    localparam int KEY_W_DEFAULT           = 4;
    localparam int KEY_DB_CYCLES_DEFAULT   = 3;
    localparam int KEY_SYNC_STAGES_DEFAULT = 2;

    // Mismatch counter width; one spare bit keeps DB_CYCLES=1 at a legal 1-bit width.
    function automatic int key_cnt_width(input int db_cycles);
        return $clog2(db_cycles) + 1;
    endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// Single-key synchroniser, debounce counter, stable level and edge pulses.
// Release pulse port exists only when KEY_INPUT_RELEASE_EN is defined.
module key_debounce_bit
    import key_input_pkg::*;
#(
    parameter int DB_CYCLES   = KEY_DB_CYCLES_DEFAULT,
    parameter int SYNC_STAGES = KEY_SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
`ifdef KEY_INPUT_RELEASE_EN
    ,
    output logic key_rel
`endif
);

    localparam int            CW       = key_cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sy_s;
    logic                   st_r;
    logic                   st_nxt_s;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_nxt_s;
    logic                   accept_s;
    logic                   press_r;

    assign sy_s = sync_r[SYNC_STAGES-1];

    // Next state: a new level must persist DB_CYCLES synchronised cycles before st follows it.
    always_comb begin
        st_nxt_s  = st_r;
        cnt_nxt_s = {CW{1'b0}};
        accept_s  = 1'b0;
        if (sy_s == st_r) begin
            cnt_nxt_s = {CW{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            st_nxt_s  = sy_s;
            cnt_nxt_s = {CW{1'b0}};
            accept_s  = 1'b1;
        end else begin
            cnt_nxt_s = cnt_r + CW'(1);
        end
    end

    // Synchroniser chain, debounce state and registered press pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r  <= {SYNC_STAGES{1'b0}};
            st_r    <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            press_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], key};
            st_r    <= st_nxt_s;
            cnt_r   <= cnt_nxt_s;
            press_r <= accept_s & sy_s;
        end
    end

    assign press = press_r;

`ifdef KEY_INPUT_RELEASE_EN
    logic rel_r;

    // Registered release pulse on an accepted 1->0 transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            rel_r <= 1'b0;
        end else begin
            rel_r <= accept_s & ~sy_s;
        end
    end

    assign key_rel = rel_r;
`endif

endmodule

// File: rtl/key_input.sv
// W-line key front end: independent synchronise + debounce per line, one-cycle press pulses.
// Define KEY_INPUT_RELEASE_EN to add the key_release pulse output.
module key_input
    import key_input_pkg::*;
#(
    parameter int W           = KEY_W_DEFAULT,
    parameter int DB_CYCLES   = KEY_DB_CYCLES_DEFAULT,
    parameter int SYNC_STAGES = KEY_SYNC_STAGES_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] keys,
    output logic [W-1:0] key_press
`ifdef KEY_INPUT_RELEASE_EN
    ,
    output logic [W-1:0] key_release
`endif
);

    for (genvar i = 0; i < W; i++) begin : g_key
        key_debounce_bit #(
            .DB_CYCLES   (DB_CYCLES),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_bit (
            .clk     (clk),
            .rst     (rst),
            .key     (keys[i]),
            .press   (key_press[i])
`ifdef KEY_INPUT_RELEASE_EN
            ,
            .key_rel (key_release[i])
`endif
        );
    end

endmodule

// File: tb/tb_key_input.sv
// Self-checking bench for key_input: directed scenarios plus random keys against a window-based model.
module tb_key_input;

    localparam int W  = 4;
    localparam int DB = 3;
    localparam int SS = 2;

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic [W-1:0] keys = 4'b0000;
    logic [W-1:0] key_press;
    int           chk_cnt  = 0;
    int           pass_cnt = 0;

`ifdef KEY_INPUT_RELEASE_EN
    logic [W-1:0] key_release;
`endif

    key_input #(.W(W), .DB_CYCLES(DB), .SYNC_STAGES(SS)) dut (
        .clk         (clk),
        .rst         (rst),
        .keys        (keys),
        .key_press   (key_press)
`ifdef KEY_INPUT_RELEASE_EN
        ,
        .key_release (key_release)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a level is accepted once the last DB synchronised samples
    // (raw samples delayed SS edges, zero if that sample predates the last reset)
    // all differ from the stable level, counting only edges since the last flip/reset.
    int           n_edge     = 0;
    int           last_reset = 0;
    int           last_flip [W];
    logic [W-1:0] raw_mem [0:4095];
    logic [W-1:0] st_m      = 4'b0000;
    logic [W-1:0] exp_press = 4'b0000;
    logic [W-1:0] exp_rel   = 4'b0000;

    function automatic logic sy_at(input int e, input int i);
        if (e - SS > last_reset) return raw_mem[e - SS][i];
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        n_edge = n_edge + 1;
        raw_mem[n_edge] = keys;
        exp_press = 4'b0000;
        exp_rel   = 4'b0000;
        if (rst) begin
            last_reset = n_edge;
            st_m = 4'b0000;
            for (int i = 0; i < W; i++) last_flip[i] = n_edge;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (n_edge - last_flip[i] >= DB) begin
                    logic all_diff;
                    all_diff = 1'b1;
                    for (int j = 0; j < DB; j++)
                        if (sy_at(n_edge - j, i) == st_m[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        st_m[i] = ~st_m[i];
                        last_flip[i] = n_edge;
                        exp_press[i] = st_m[i];
                        exp_rel[i]   = ~st_m[i];
                    end
                end
            end
        end
    end

`ifdef KEY_INPUT_RELEASE_EN
    wire [2*W-1:0] obs  = {key_release, key_press};
    wire [2*W-1:0] expv = {exp_rel, exp_press};
`else
    wire [W-1:0] obs  = key_press;
    wire [W-1:0] expv = exp_press;
`endif

    task automatic test_idle(input int cycles);
        keys = 4'b0000;
        for (int c = 1; c <= cycles; c++) begin
            @(posedge clk); #1;
            chk_cnt++;
            if (obs !== expv) $display("FAIL idle c=%0d got %b want %b", c, obs, expv);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        int pulses = 0;
        int at = -1;
        rst  = 1'b1;
        keys = 4'b1111;
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); #1;
            chk_cnt++;
            if (key_press !== 4'b0000) $display("FAIL reset_hold c=%0d got %b want 0000", c, key_press);
            else pass_cnt++;
        end
        rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            chk_cnt++;
            if (obs !== expv) $display("FAIL reset_model c=%0d got %b want %b", c, obs, expv);
            else pass_cnt++;
            if (key_press !== 4'b0000) begin
                pulses++;
                if (key_press === 4'b1111) at = c;
            end
        end
        chk_cnt++;
        if (pulses != 1 || at != 5) $display("FAIL reset_pulse got pulses=%0d at=%0d want 1 at 5", pulses, at);
        else pass_cnt++;
    endtask

    task automatic test_single();
        int pulses = 0;
        int at = -1;
        for (int c = 1; c <= 12; c++) begin
            keys = (c <= 5) ? 4'b0010 : 4'b0000;
            @(posedge clk); #1;
            chk_cnt++;
            if (obs !== expv) $display("FAIL single_model c=%0d got %b want %b", c, obs, expv);
            else pass_cnt++;
            if (key_press !== 4'b0000) begin
                pulses++;
                if (key_press === 4'b0010) at = c;
            end
        end
        chk_cnt++;
        if (pulses != 1 || at != 5) $display("FAIL single_pulse got pulses=%0d at=%0d want 1 at 5", pulses, at);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        int pulses = 0;
        for (int c = 1; c <= 10; c++) begin
            keys = (c <= 2) ? 4'b0001 : 4'b0000;
            @(posedge clk); #1;
            chk_cnt++;
            if (obs !== expv) $display("FAIL glitch_model c=%0d got %b want %b", c, obs, expv);
            else pass_cnt++;
            if (key_press !== 4'b0000) pulses++;
        end
        chk_cnt++;
        if (pulses != 0) $display("FAIL glitch_pulse got pulses=%0d want 0", pulses);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        int pulses = 0;
        int both = 0;
        for (int c = 1; c <= 12; c++) begin
            keys = (c <= 6) ? 4'b1010 : 4'b0000;
            @(posedge clk); #1;
            chk_cnt++;
            if (obs !== expv) $display("FAIL simul_model c=%0d got %b want %b", c, obs, expv);
            else pass_cnt++;
            if (key_press !== 4'b0000) pulses++;
            if (key_press === 4'b1010) both++;
        end
        chk_cnt++;
        if (pulses != 1 || both != 1) $display("FAIL simul_pulse got pulses=%0d both=%0d want 1 1", pulses, both);
        else pass_cnt++;
    endtask

    task automatic test_hold_repress();
        int pulses = 0;
        for (int c = 1; c <= 36; c++) begin
            keys = (c <= 20 || (c > 25 && c <= 30)) ? 4'b0001 : 4'b0000;
            @(posedge clk); #1;
            chk_cnt++;
            if (obs !== expv) $display("FAIL repress_model c=%0d got %b want %b", c, obs, expv);
            else pass_cnt++;
            if (key_press[0] === 1'b1) pulses++;
        end
        chk_cnt++;
        if (pulses != 2) $display("FAIL repress_pulse got pulses=%0d want 2", pulses);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int early = 0;
        int pulses = 0;
        int at = -1;
        keys = 4'b0100;
        for (int c = 1; c <= 4; c++) begin
            rst = (c >= 3) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            chk_cnt++;
            if (obs !== expv) $display("FAIL midrst_model c=%0d got %b want %b", c, obs, expv);
            else pass_cnt++;
            if (key_press !== 4'b0000) early++;
        end
        rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            chk_cnt++;
            if (obs !== expv) $display("FAIL midrst_model2 c=%0d got %b want %b", c, obs, expv);
            else pass_cnt++;
            if (key_press !== 4'b0000) begin
                pulses++;
                if (key_press === 4'b0100) at = c;
            end
        end
        chk_cnt++;
        if (early != 0 || pulses != 1 || at != 5)
            $display("FAIL midrst_pulse got early=%0d pulses=%0d at=%0d want 0 1 5", early, pulses, at);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int c = 1; c <= 400; c++) begin
            if ($urandom_range(0, 3) == 0) keys = 4'($urandom);
            rst = ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            chk_cnt++;
            if (obs !== expv) $display("FAIL random_model c=%0d got %b want %b", c, obs, expv);
            else pass_cnt++;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle(10);
        test_single();
        test_idle(6);
        test_glitch();
        test_idle(6);
        test_simultaneous();
        test_idle(6);
        test_hold_repress();
        test_idle(6);
        test_reset_mid();
        test_idle(10);
        test_random();
        test_idle(10);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
